blake_round_seq: RTL and testbench

Sequencer for the BLAKE-512 compression datapath. Walks NROUNDS rounds × 8 G-function calls (G0-G3 columns, G4-G7 diagonals). Drives round/sigma indices into the shared sigma/constant ROM, captures the two message-word indices per G call and issues each call to the G datapath with a valid/ready handshake. Brackets the compression with init and finalization strobes; sits between the block-level host FSM and the G datapath.

---
 rtl/blake_round_seq.sv | 143 ++++++++++++++
 tb/tb_blake_round_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/blake_round_seq.sv
// BLAKE-512 round sequencer: walks NROUNDS x 8 G calls with sigma lookup and handshake.
// Optional cycle counter perf_cyc_o under `BLAKE_ROUND_SEQ_PERF_EN.
module blake_round_seq #(
  parameter int NROUNDS = 16,
  parameter int PERF_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic             busy_o,
  output logic             init_o,
  output logic [3:0]       round_idx_o,
  output logic [3:0]       sigma_idx_o,
  input  logic [3:0]       sigma_i,
  output logic             g_valid_o,
  input  logic             g_ready_i,
  output logic [2:0]       g_sel_o,
  output logic [3:0]       g_m0_idx_o,
  output logic [3:0]       g_m1_idx_o,
  input  logic             g_idle_i,
  output logic             final_o,
`ifdef BLAKE_ROUND_SEQ_PERF_EN
  output logic [PERF_W-1:0] perf_cyc_o,
`endif
  output logic             done_o
);

  typedef enum logic [2:0] {
    IDLE, INIT, SIG_A, SIG_B,
    ISSUE, DRAIN, FIN, DONE
  } state_e;

  localparam logic [3:0] LAST_R = 4'(NROUNDS - 1);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [2:0] gsel_q, gsel_d;
  logic [3:0] sig_a_q, sig_a_d;
  logic [3:0] sig_b_q, sig_b_d;
  logic       last_g;

  assign last_g = (gsel_q == 3'd7) && (round_q == LAST_R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      gsel_q  <= '0;
      sig_a_q <= '0;
      sig_b_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      gsel_q  <= gsel_d;
      sig_a_q <= sig_a_d;
      sig_b_q <= sig_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = INIT;
      INIT:  state_d = SIG_A;
      SIG_A: state_d = SIG_B;
      SIG_B: state_d = ISSUE;
      ISSUE: if (g_ready_i) state_d = last_g ? DRAIN : SIG_A;
      DRAIN: if (g_idle_i) state_d = FIN;
      FIN:   state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    round_d = round_q;
    gsel_d  = gsel_q;
    sig_a_d = sig_a_q;
    sig_b_d = sig_b_q;
    case (state_q)
      INIT: begin
        round_d = '0;
        gsel_d  = '0;
      end
      SIG_A: sig_a_d = sigma_i;
      SIG_B: sig_b_d = sigma_i;
      ISSUE: begin
        if (g_ready_i) begin
          if (gsel_q != 3'd7) begin
            gsel_d = gsel_q + 3'd1;
          end else if (round_q != LAST_R) begin
            gsel_d  = '0;
            round_d = round_q + 4'd1;
          end
        end
      end
      // IDLE must present zero indices
      DONE: begin
        round_d = '0;
        gsel_d  = '0;
        sig_a_d = '0;
        sig_b_d = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    init_o      = (state_q == INIT);
    g_valid_o   = (state_q == ISSUE);
    final_o     = (state_q == FIN);
    done_o      = (state_q == DONE);
    round_idx_o = round_q;
    g_sel_o     = gsel_q;
    g_m0_idx_o  = sig_a_q;
    g_m1_idx_o  = sig_b_q;
    sigma_idx_o = '0;
    if (state_q == SIG_A) sigma_idx_o = {gsel_q, 1'b0};
    if (state_q == SIG_B) sigma_idx_o = {gsel_q, 1'b1};
  end

`ifdef BLAKE_ROUND_SEQ_PERF_EN
  logic [PERF_W-1:0] perf_q, perf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  always_comb begin
    perf_d = perf_q;
    if (state_q == IDLE) begin
      if (start_i) perf_d = '0;
    end else if (perf_q != '1) begin
      perf_d = perf_q + 1'b1;
    end
  end

  assign perf_cyc_o = perf_q;
`endif

endmodule

// File: tb/tb_blake_round_seq.sv
// Directed bench for blake_round_seq with a BLAKE-512 sigma ROM model.
// A second NROUNDS=1 instance covers the short-round build.
module tb_blake_round_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic g_ready;
  logic g_idle;

  logic       busy, init, valid, fin, done;
  logic [3:0] round, sidx, sig, m0, m1;
  logic [2:0] sel;
  logic       b_busy, b_init, b_valid, b_fin, b_done;
  logic [3:0] b_round, b_sidx, b_sig, b_m0, b_m1;
  logic [2:0] b_sel;
`ifdef BLAKE_ROUND_SEQ_PERF_EN
  logic [15:0] perf, b_perf;
`endif

  always #5 clk = ~clk;

  localparam logic [63:0] SROW [10] = '{
    64'h0123456789abcdef, 64'hea489fd61c02b753,
    64'hb8c052fdae367194, 64'h7931dcbe265a40f8,
    64'h905724afe1bc683d, 64'h2c6a0b834d75fe19,
    64'hc51fed4a0763928b, 64'hdb7ec13950f4862a,
    64'h6fe9b308c2d714a5, 64'ha2847615fb9e3cd0
  };

  function automatic logic [3:0] rom(input logic [3:0] r,
                                     input logic [3:0] i);
    logic [63:0] row;
    row = SROW[int'(r) % 10];
    return row[63 - 4 * int'(i) -: 4];
  endfunction

  assign sig   = rom(round, sidx);
  assign b_sig = rom(b_round, b_sidx);

  blake_round_seq dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .busy_o(busy), .init_o(init), .round_idx_o(round),
    .sigma_idx_o(sidx), .sigma_i(sig), .g_valid_o(valid),
    .g_ready_i(g_ready), .g_sel_o(sel), .g_m0_idx_o(m0),
    .g_m1_idx_o(m1), .g_idle_i(g_idle), .final_o(fin),
`ifdef BLAKE_ROUND_SEQ_PERF_EN
    .perf_cyc_o(perf),
`endif
    .done_o(done)
  );

  blake_round_seq #(.NROUNDS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .busy_o(b_busy), .init_o(b_init), .round_idx_o(b_round),
    .sigma_idx_o(b_sidx), .sigma_i(b_sig), .g_valid_o(b_valid),
    .g_ready_i(g_ready), .g_sel_o(b_sel), .g_m0_idx_o(b_m0),
    .g_m1_idx_o(b_m1), .g_idle_i(g_idle), .final_o(b_fin),
`ifdef BLAKE_ROUND_SEQ_PERF_EN
    .perf_cyc_o(b_perf),
`endif
    .done_o(b_done)
  );

  logic [23:0] outs;
  assign outs = {busy, init, round, sidx, valid,
                 sel, m0, m1, fin, done};

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int cyc, nbusy, ndone, hs, hsb, sig_err;
  int t_init, t_fin, t_done, tb_done;
  int stall_left, idle_left, stall_cyc, stall_bad;
  int rst_round;
  bit mid_start, mid_done, done_start, aborted;
  logic [7:0] pairs [128];

  task automatic run();
    cyc = 0; nbusy = 0; ndone = 0; hs = 0; hsb = 0;
    sig_err = 0; stall_cyc = 0; stall_bad = 0;
    t_init = -1; t_fin = -1; t_done = -1; tb_done = -1;
    mid_done = 0; aborted = 0;
    @(negedge clk);
    start = 1'b1;
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (rst_round >= 0 && busy && int'(round) == rst_round) begin
        rst_n = 1'b0;
        #1;
        check("rst_outs_zero", outs, 0);
        aborted = 1;
        break;
      end
      if (busy) nbusy++;
      if (init) t_init = cyc;
      if (fin) t_fin = cyc;
      if (done) begin t_done = cyc; ndone++; end
      if (b_done) tb_done = cyc;
      start = 1'b0;
      if (mid_start && !mid_done && round == 4'd4) begin
        start = 1'b1;
        mid_done = 1;
      end
      if (done_start && done) start = 1'b1;
      g_ready = 1'b1;
      if (valid && round == 4'd3 && sel == 3'd2) begin
        stall_cyc++;
        if ({m0, m1} != 8'hdc) stall_bad++;
        if (stall_left > 0) begin
          g_ready = 1'b0;
          stall_left--;
        end
      end
      g_idle = 1'b1;
      if (hs == 128 && idle_left > 0 && busy) begin
        g_idle = 1'b0;
        idle_left--;
      end
      if (valid && g_ready) begin
        hs++;
        pairs[{round, sel}] = {m0, m1};
        if ({m0, m1} != {rom(round, {sel, 1'b0}),
                         rom(round, {sel, 1'b1})})
          sig_err++;
      end
      if (b_valid && g_ready) hsb++;
      if (done) break;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    g_ready = 1'b1; g_idle = 1'b1;
    stall_left = 0; idle_left = 0; rst_round = -1;
    mid_start = 0; done_start = 0;
    #3;
    check("reset_outs_zero", outs, 0);
`ifdef BLAKE_ROUND_SEQ_PERF_EN
    check("reset_perf", perf, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs_zero", outs, 0);

    run();
    check("t1_init_cyc", t_init, 1);
    check("t1_final_cyc", t_fin, 387);
    check("t1_done_cyc", t_done, 388);
    check("t1_handshakes", hs, 128);
    check("t1_busy_cycles", nbusy, 388);
    check("t1_done_count", ndone, 1);
    check("t1_sigma_errs", sig_err, 0);
    check("r1_g0_pair", pairs[7'd8], 8'hea);
    check("r9_g7_pair", pairs[7'd79], 8'hd0);
    check("r10_g0_pair", pairs[7'd80], 8'h01);
    check("r15_g4_pair", pairs[7'd124], 8'h4d);
    check("r3_g2_pair", pairs[7'd26], 8'hdc);
    check("nr1_handshakes", hsb, 8);
    check("nr1_done_cyc", tb_done, 28);
    @(negedge clk);
    check("t1_idle_after", outs, 0);
`ifdef BLAKE_ROUND_SEQ_PERF_EN
    check("t1_perf", perf, 388);
`endif

    stall_left = 5; idle_left = 4;
    run();
    check("t2_stall_cycles", stall_cyc, 6);
    check("t2_stall_stable", stall_bad, 0);
    check("t2_final_cyc", t_fin, 396);
    check("t2_done_cyc", t_done, 397);
    check("t2_handshakes", hs, 128);
    check("t2_done_count", ndone, 1);
    @(negedge clk);

    mid_start = 1; done_start = 1;
    run();
    check("t3_done_cyc", t_done, 388);
    check("t3_done_count", ndone, 1);
    @(negedge clk);
    start = 1'b0;
    check("t3_done_start_ign", busy, 0);
    @(negedge clk);
    check("t3_still_idle", busy, 0);
    mid_start = 0; done_start = 0;

    rst_round = 7;
    run();
    check("t4_aborted", aborted, 1);
    check("t4_no_done", ndone, 0);
    rst_round = -1;
    @(negedge clk);
    check("t4_idle_in_rst", outs, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_idle_after_rst", busy, 0);
    run();
    check("t4_fresh_done_cyc", t_done, 388);
    check("t4_fresh_handshakes", hs, 128);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
